// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the round-robin SPI master scheduler.
// Optional burst mode is selected with the SPI_SCHED_BURST_EN macro.
package spi_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_XFER,
      ST_DONE,
      ST_GAP
   } state_t;

   // sclk toggles per frame: cpha=0 frames, and cpha=1 frames whose load edge is the ss rise
   localparam logic [4:0] TOGGLES_CPHA0 = 5'd20;
   localparam logic [4:0] TOGGLES_CPHA1 = 5'd18;

   // Frames granted back-to-back to one requester before re-arbitration
   localparam logic [2:0] BURST_LIMIT = 3'd4;

   // True when sclk toggle number n (1-based) is one of the eight shift edges.
   // cont marks a cpha=1 burst continuation, whose load edge is toggle 2 instead of the ss rise.
   function automatic logic is_shift_toggle(input logic [4:0] n, input logic cpha, input logic cont);
      logic [4:0] lo;
      logic [4:0] hi;
      if (!cpha) begin
         return n[0] && (n >= 5'd3) && (n <= 5'd17);
      end
      lo = cont ? 5'd4 : 5'd2;
      hi = cont ? 5'd18 : 5'd16;
      return !n[0] && (n >= lo) && (n <= hi);
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module spi_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant
);

   localparam int PW = $clog2(NUM_REQ);

   // Scan requesters starting at ptr, wrapping once, and grant the first one found
   always_comb begin
      logic found;
      int   pos;
      logic [PW-1:0] idx;
      // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(ptr) + i;
         idx = PW'((pos >= NUM_REQ) ? pos - NUM_REQ : pos);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_master_sched.sv
// Round-robin SPI master: arbitrates NUM_REQ requesters onto one SPI bus, one byte per frame.
// Holds the frame FSM, sclk divider, toggle counter and shift registers.
// Define SPI_SCHED_BURST_EN to let a requester keep the bus for up to BURST_LIMIT frames.
module spi_master_sched
   import spi_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_SS  = 4,
   parameter int CLK_DIV = 4,
   parameter int GAP     = 2
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic [NUM_REQ-1:0]                                   req,
   input  logic [8*NUM_REQ-1:0]                                 req_data,
   input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)*NUM_REQ-1:0] req_ss_sel,
   input  logic                                                 cfg_cpol,
   input  logic                                                 cfg_cpha,
   output logic [NUM_REQ-1:0]                                   grant,
   output logic                                                 done,
   output logic [7:0]                                           rd_data,
   output logic                                                 busy,
   output logic                                                 sclk,
   output logic [NUM_SS-1:0]                                    ss,
   output logic                                                 mosi,
   input  logic                                                 miso
);

   localparam int SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
   localparam int PW  = $clog2(NUM_REQ);
   localparam int DW  = $clog2(CLK_DIV);
   localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
`ifdef SPI_SCHED_BURST_EN
   localparam logic BURST_EN = 1'b1;
`else
   localparam logic BURST_EN = 1'b0;
`endif

   state_t              state, state_nxt;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [PW-1:0]       rr_ptr, win, win_nxt;
   logic [7:0]          arb_data, win_data, tx_sr, rx_sr;
   logic [SSW-1:0]      arb_sel;
   logic [NUM_SS-1:0]   arb_ss;
   logic                arb_sel_ok, sel_ok_q, cpol_q, cpha_q, cont_q;
   logic [DW-1:0]       div;
   logic [4:0]          tcnt, tog_n, tog_total;
   logic [2:0]          burst_cnt;
   logic [GW-1:0]       gap_cnt;
   logic                toggle_tick, pre_tick, last_toggle, cont_next;

   spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_grant)
   );

   // Decode the arbitration winner and the current owner into their byte and slave select
   always_comb begin
      win_nxt  = '0;
      arb_data = '0;
      arb_sel  = '0;
      win_data = '0;
      arb_ss   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) win_nxt = PW'(i);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == win_nxt) begin
            arb_data = req_data[i*8 +: 8];
            arb_sel  = req_ss_sel[i*SSW +: SSW];
         end
         if (PW'(i) == win) win_data = req_data[i*8 +: 8];
      end
      for (int j = 0; j < NUM_SS; j++) begin
         if (SSW'(j) == arb_sel) arb_ss[j] = 1'b1;
      end
      arb_sel_ok = (int'(arb_sel) < NUM_SS);
   end

   assign tog_n       = tcnt + 5'd1;
   assign tog_total   = (cpha_q && !cont_q) ? TOGGLES_CPHA1 : TOGGLES_CPHA0;
   assign toggle_tick = (state == ST_XFER) && (div == DW'(CLK_DIV - 1));
   assign pre_tick    = (state == ST_XFER) && (div == DW'(CLK_DIV - 2)) && is_shift_toggle(tog_n, cpha_q, cont_q);
   assign last_toggle = toggle_tick && (tog_n == tog_total);
   assign cont_next   = BURST_EN && req[win] && (burst_cnt < BURST_LIMIT - 3'd1);

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: IDLE -> ARB -> XFER -> DONE -> (XFER in a burst | GAP) -> IDLE
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (|req) state_nxt = ST_ARB;
         ST_ARB:  state_nxt = (|arb_grant) ? ST_XFER : ST_IDLE;
         ST_XFER: if (last_toggle) state_nxt = ST_DONE;
         ST_DONE: state_nxt = cont_q ? ST_XFER : ST_GAP;
         ST_GAP:  if (gap_cnt == GW'(GAP - 1)) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame datapath: latch at grant, divide sclk, shift bits, publish the rx byte, advance the pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: datapath registers are reset as well, so pins and rd_data are defined straight out of reset.
         rr_ptr    <= '0;
         win       <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         rd_data   <= '0;
         ss        <= '0;
         mosi      <= 1'b0;
         sclk      <= cfg_cpol;
         cpol_q    <= cfg_cpol;
         cpha_q    <= 1'b0;
         sel_ok_q  <= 1'b0;
         div       <= '0;
         tcnt      <= '0;
         cont_q    <= 1'b0;
         burst_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: sclk <= cfg_cpol;
            ST_ARB: if (|arb_grant) begin
               win       <= win_nxt;
               tx_sr     <= arb_data;
               sel_ok_q  <= arb_sel_ok;
               ss        <= arb_ss;
               cpol_q    <= cfg_cpol;
               cpha_q    <= cfg_cpha;
               sclk      <= cfg_cpol;
               div       <= '0;
               tcnt      <= '0;
               cont_q    <= 1'b0;
               burst_cnt <= '0;
            end
            ST_XFER: begin
               // mosi and the miso sample move one clk ahead of each shift edge
               if (pre_tick) begin
                  mosi  <= tx_sr[0];
                  tx_sr <= tx_sr >> 1;
                  rx_sr <= {miso, rx_sr[7:1]};
               end
               if (toggle_tick) begin
                  div  <= '0;
                  sclk <= ~sclk;
                  tcnt <= tog_n;
               end else begin
                  div <= div + 1'b1;
               end
               if (last_toggle) begin
                  rd_data <= sel_ok_q ? rx_sr : 8'h00;
                  cont_q  <= cont_next;
                  if (!cont_next) ss <= '0;
               end
            end
            ST_DONE: begin
               rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               if (cont_q) begin
                  burst_cnt <= burst_cnt + 3'd1;
                  tx_sr     <= win_data;
                  div       <= '0;
                  tcnt      <= '0;
               end else begin
                  gap_cnt <= '0;
               end
            end
            ST_GAP: gap_cnt <= gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // Grant follows the arbiter during ARB and the latched owner for the rest of the frame
   always_comb begin
      grant = '0;
      if (state == ST_ARB)
         grant = arb_grant;
      else if ((state == ST_XFER) || ((state == ST_DONE) && cont_q))
         grant = NUM_REQ'(1) << win;
   end

   assign done = (state == ST_DONE);
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_master_sched.sv
// Self-checking bench for spi_master_sched with a behavioural SPI slave per ss line.
// The burst sequence is compiled only when SPI_SCHED_BURST_EN is defined.
module tb_spi_master_sched;

   localparam int NUM_REQ = 4;
   localparam int NUM_SS  = 5;
   localparam int CLK_DIV = 4;
   localparam int GAP     = 2;
   localparam int SSW     = 3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [NUM_REQ-1:0]     req = '0;
   logic [8*NUM_REQ-1:0]   req_data = '0;
   logic [SSW*NUM_REQ-1:0] req_ss_sel = '0;
   logic                   cfg_cpol = 1'b0;
   logic                   cfg_cpha = 1'b0;
   logic [NUM_REQ-1:0]     grant;
   logic                   done;
   logic [7:0]             rd_data;
   logic                   busy;
   logic                   sclk;
   logic [NUM_SS-1:0]      ss;
   logic                   mosi;
   logic                   miso = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   spi_master_sched #(
      .NUM_REQ(NUM_REQ), .NUM_SS(NUM_SS), .CLK_DIV(CLK_DIV), .GAP(GAP)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_ss_sel(req_ss_sel),
      .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .grant(grant), .done(done), .rd_data(rd_data),
      .busy(busy), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic [7:0] slave_tx [NUM_SS];
   logic       slave_cpol = 1'b0;
   logic       slave_cpha = 1'b0;
   logic [7:0] s_sh = '0;
   logic [7:0] s_last = '0;
   int         s_cnt = 0;
   int         s_sel = 0;
   int         s_commits = 0;
   int         s_toggles = 0;
   logic       s_active = 1'b0;
   logic       prev_sclk = 1'b0;

   task slave_active_edge();
      s_cnt++;
      if (s_cnt == 1) begin
         miso = slave_tx[s_sel][0];
      end else if (s_cnt <= 9) begin
         s_sh = {mosi, s_sh[7:1]};
         if (s_cnt <= 8) miso = slave_tx[s_sel][s_cnt-1];
      end else begin
         s_last = s_sh;
         s_commits++;
         s_cnt = 0;
      end
   endtask

   // Slave: counts active edges (load, 8 shifts, commit), wraps, deselects at a clk low phase with ss idle
   always @(ss, sclk, negedge clk) begin
      if (sclk !== prev_sclk) begin
         prev_sclk = sclk;
         s_toggles++;
         if (s_active && (slave_cpha ? (sclk === slave_cpol) : (sclk !== slave_cpol)))
            slave_active_edge();
      end
      if ((ss != '0) && !s_active) begin
         s_active = 1'b1;
         s_cnt = 0;
         for (int i = 0; i < NUM_SS; i++) if (ss[i]) s_sel = i;
         if (slave_cpha) slave_active_edge();
      end
      if (!clk && (ss == '0) && s_active) begin
         s_active = 1'b0;
         miso = 1'b0;
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      int         idx;
      logic [7:0] data;
      logic [2:0] sel;
      logic       cpol;
      logic       cpha;
      logic [7:0] stx;
      logic [7:0] exp_rd;
      logic [4:0] exp_ss;
      int         exp_len;
      int         exp_tog;
   } vec_t;

   vec_t vecs[8];

   task automatic run_frame(input vec_t v);
      int cyc, gap_busy, commits0, tog0;
      logic [4:0] ss_seen;
      bit got;
      cfg_cpol = v.cpol;  cfg_cpha = v.cpha;
      slave_cpol = v.cpol; slave_cpha = v.cpha;
      req_data[v.idx*8 +: 8]       = v.data;
      req_ss_sel[v.idx*SSW +: SSW] = v.sel;
      if (int'(v.sel) < NUM_SS) slave_tx[v.sel] = v.stx;
      repeat (3) @(negedge clk);
      check("idle_sclk_before", sclk, v.cpol);
      commits0 = s_commits;
      req[v.idx] = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (grant != '0) got = 1;
      end
      if (!got) begin
         check("grant_timeout", 0, 1);
         req = '0;
         return;
      end
      check("grant_onehot", grant, 32'(1) << v.idx);
      check("busy_at_grant", busy, 1);
      tog0 = s_toggles;
      cyc = 1;
      ss_seen = '0;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         cyc++;
         ss_seen |= ss;
         if (cyc == 4) begin
            // requester lets go and the config flips mid-frame: neither may disturb the frame
            req[v.idx] = 1'b0;
            cfg_cpol = ~v.cpol;
            cfg_cpha = ~v.cpha;
         end
         if (done) got = 1;
      end
      if (!got) begin
         check("done_timeout", 0, 1);
         return;
      end
      check("frame_len", cyc, v.exp_len);
      check("sclk_toggles", s_toggles - tog0, v.exp_tog);
      check("rd_data", rd_data, v.exp_rd);
      check("ss_lines_used", ss_seen, v.exp_ss);
      check("sclk_idle_at_done", sclk, v.cpol);
      check("ss_low_at_done", ss, 0);
      check("grant_low_at_done", grant, 0);
      if (int'(v.sel) < NUM_SS) begin
         check("slave_commits", s_commits - commits0, 1);
         check("slave_rx", s_last, v.data);
      end else begin
         check("no_slave_commit", s_commits - commits0, 0);
      end
      gap_busy = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (i == 0) check("done_one_cycle", done, 0);
         if (i == 0) check("rd_data_held", rd_data, v.exp_rd);
         if (busy) gap_busy++;
         else got = 1;
      end
      check("gap_busy_cycles", gap_busy, GAP);
   endtask

   initial begin
      int cnt, seen_done, ss_bad, gap_c, exp_w;
      bit got;

      for (int i = 0; i < NUM_SS; i++) slave_tx[i] = 8'h00;

      //               idx data   sel   cpol cpha stx    rd     ss        len tog
      vecs[0] = '{0, 8'hA5, 3'd1, 1'b0, 1'b0, 8'h3C, 8'h3C, 5'b00010, 82, 20};
      vecs[1] = '{0, 8'hA5, 3'd1, 1'b0, 1'b1, 8'h3C, 8'h3C, 5'b00010, 74, 18};
      vecs[2] = '{0, 8'hA5, 3'd1, 1'b1, 1'b0, 8'h3C, 8'h3C, 5'b00010, 82, 20};
      vecs[3] = '{0, 8'hA5, 3'd1, 1'b1, 1'b1, 8'h3C, 8'h3C, 5'b00010, 74, 18};
      vecs[4] = '{2, 8'h5A, 3'd3, 1'b0, 1'b0, 8'h96, 8'h96, 5'b01000, 82, 20};
      vecs[5] = '{1, 8'hFF, 3'd5, 1'b0, 1'b0, 8'hC3, 8'h00, 5'b00000, 82, 20};
      vecs[6] = '{3, 8'h01, 3'd0, 1'b1, 1'b1, 8'h80, 8'h80, 5'b00001, 74, 18};
      vecs[7] = '{1, 8'hC3, 3'd4, 1'b0, 1'b1, 8'h7E, 8'h7E, 5'b10000, 74, 18};

      // ---- reset state ----
      cfg_cpol = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_sclk_cpol1", sclk, 1);
      cfg_cpol = 1'b0;
      @(negedge clk);
      check("reset_sclk_cpol0", sclk, 0);
      check("reset_grant", grant, 0);
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_ss", ss, 0);
      check("reset_mosi", mosi, 0);
      reset = 1'b0;
      @(negedge clk);

      // ---- table-driven frames ----
      for (int k = 0; k < 8; k++) run_frame(vecs[k]);

      // ---- all requesters held: rotation and inter-frame spacing ----
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; slave_cpol = 1'b0; slave_cpha = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[i*8 +: 8] = 8'h10 + 8'(i);
         req_ss_sel[i*SSW +: SSW] = 3'd1;
      end
      @(negedge clk);
      req = '1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (grant != '0) got = 1;
      end
      if (!got) check("rr_first_grant_timeout", 0, 1);
      for (int f = 0; f < 5 && got; f++) begin
         exp_w = f % NUM_REQ;
         check("rr_grant_order", grant, 32'(1) << exp_w);
         got = 0;
         for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
         end
         if (!got) begin
            check("rr_done_timeout", 0, 1);
         end else begin
            check("rr_rd_data", rd_data, 8'h3C);
            check("rr_slave_rx", s_last, 8'h10 + 8'(exp_w));
            if (f < 4) begin
               gap_c = 0;
               ss_bad = 0;
               got = 0;
               for (int i = 0; i < 20 && !got; i++) begin
                  @(negedge clk);
                  gap_c++;
                  if (ss != '0) ss_bad++;
                  if (grant != '0) got = 1;
               end
               // GAP cycles, one IDLE cycle, then the ARB cycle that shows the next grant
               check("rr_done_to_grant", gap_c, GAP + 2);
               check("rr_ss_low_between", ss_bad, 0);
            end
         end
      end
      req = '0;
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);

      // ---- reset mid-frame at toggle 7 ----
      cfg_cpol = 1'b0; cfg_cpha = 1'b0;
      req_data[7:0] = 8'hA5;
      req_ss_sel[SSW-1:0] = 3'd1;
      repeat (2) @(negedge clk);
      cnt = s_toggles;
      req[0] = 1'b1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (s_toggles - cnt >= 7) got = 1;
      end
      if (!got) check("midreset_toggle_timeout", 0, 1);
      reset = 1'b1;
      req = '0;
      @(negedge clk);
      check("midreset_ss", ss, 0);
      check("midreset_grant", grant, 0);
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      reset = 1'b0;
      seen_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      check("midreset_no_done", seen_done, 0);
      run_frame(vecs[0]);

`ifdef SPI_SCHED_BURST_EN
      // ---- burst: req[2] held for 6 frames ----
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; slave_cpol = 1'b0; slave_cpha = 1'b0;
      req_data[2*8 +: 8] = 8'h6B;
      req_ss_sel[2*SSW +: SSW] = 3'd2;
      slave_tx[2] = 8'h9D;
      @(negedge clk);
      req[2] = 1'b1;
      seen_done = 0;
      ss_bad = 0;
      gap_c = 0;
      for (int i = 0; i < 2000 && seen_done < 6; i++) begin
         @(negedge clk);
         if (seen_done >= 1 && seen_done < 4 && ss == '0) ss_bad++;
         if (seen_done == 4 && ss == '0) gap_c++;
         if (done) begin
            seen_done++;
            check("burst_rd_data", rd_data, 8'h9D);
            check("burst_slave_rx", s_last, 8'h6B);
            if (seen_done == 5) req[2] = 1'b0;
         end
      end
      check("burst_frames", seen_done, 6);
      check("burst_ss_held", ss_bad, 0);
      check("burst_gap_after_4", gap_c > 0, 1);
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so a stuck design still reaches a verdict
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
